// File: rtl/imem_loadable_pkg.sv
// Shared CPU6 definitions: opcode constants, default NOP word, load FSM states.
package imem_loadable_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b0111;
  localparam logic [3:0] OP_JMP = 4'b1100;

  // All-zero word decodes as OP_NOP with a zero operand.
  localparam logic [9:0] NOP_WORD_DEF = {OP_NOP, 6'b000000};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } imem_state_e;

endpackage

// File: rtl/ram_sdp_sync.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// The array has no reset; the owner masks unloaded contents.
module ram_sdp_sync #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the word on an enabled edge.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read port: registered data, held while re is low.
  always_ff @(posedge clk) begin
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory for the 6-bit CPU. A valid/ready load port
// fills the array from word 0; fetches past the loaded length return NOP.
module imem_loadable
  import imem_loadable_pkg::*;
#(
  parameter int                DATA_W   = 10,
  parameter int                ADDR_W   = 6,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LOAD_START,
  input  logic              WR_VALID,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_LAST,
  output logic              WR_READY,
  output logic              LOAD_DONE,
  output logic [ADDR_W:0]   LEN,
  input  logic              FETCH_EN,
  input  logic [ADDR_W-1:0] AD,
  output logic [DATA_W-1:0] Q,
  output logic              Q_VALID,
  output logic              BUSY
);

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  imem_state_e       state_q, state_d;
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W:0]   len_q;
  logic              wr_fire;
  logic              wr_end;
  logic              fetch_hit;
  logic              hit_p1;
  logic              vld_p1;
  logic              load_done_q;
  logic [DATA_W-1:0] ram_rd;

  // AD is zero-extended so LEN == DEPTH still compares correctly.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a,
                                         input logic [ADDR_W:0]   len);
    return ({1'b0, a} < len);
  endfunction

  assign WR_READY  = (state_q == ST_LOAD);
  assign BUSY      = (state_q == ST_LOAD);
  assign LEN       = len_q;
  assign LOAD_DONE = load_done_q;
  assign wr_fire   = WR_VALID && WR_READY;
  // Load ends on the tagged last beat or when the final slot is written.
  assign wr_end    = wr_fire && (WR_LAST || (ptr_q == LAST_PTR));
  // Only a RUN-state fetch inside the loaded program reads the array.
  assign fetch_hit = (state_q == ST_RUN) && addr_in_range(AD, len_q);

  // Next-state logic for the RUN/LOAD controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (LOAD_START) state_d = ST_LOAD;
      ST_LOAD: if (wr_end)     state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Write pointer and program length: cleared on load start, bumped per beat.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= '0;
      len_q <= '0;
    end else if ((state_q == ST_RUN) && LOAD_START) begin
      ptr_q <= '0;
      len_q <= '0;
    end else if (wr_fire) begin
      ptr_q <= ptr_q + 1'b1;
      len_q <= len_q + 1'b1;
    end
  end

  // One-cycle completion pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) load_done_q <= 1'b0;
    else        load_done_q <= wr_end;
  end

  // Fetch stage p0 -> p1: remember whether the RAM output is meaningful.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hit_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (FETCH_EN) begin
      hit_p1 <= fetch_hit;
      vld_p1 <= (state_q == ST_RUN);
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  ram_sdp_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk (CLK),
    .we  (wr_fire),
    .wa  (ptr_q[ADDR_W-1:0]),
    .wd  (WR_DATA),
    .re  (FETCH_EN && fetch_hit),
    .ra  (AD),
    .rd  (ram_rd)
  );

  assign Q       = hit_p1 ? ram_rd : NOP_WORD;
  assign Q_VALID = vld_p1;

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       LOAD_START;
  logic       WR_VALID;
  logic [9:0] WR_DATA;
  logic       WR_LAST;
  logic       WR_READY;
  logic       LOAD_DONE;
  logic [6:0] LEN;
  logic       FETCH_EN;
  logic [5:0] AD;
  logic [9:0] Q;
  logic       Q_VALID;
  logic       BUSY;

  int total = 0;
  int bad   = 0;

  imem_loadable dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LOAD_START (LOAD_START),
    .WR_VALID   (WR_VALID),
    .WR_DATA    (WR_DATA),
    .WR_LAST    (WR_LAST),
    .WR_READY   (WR_READY),
    .LOAD_DONE  (LOAD_DONE),
    .LEN        (LEN),
    .FETCH_EN   (FETCH_EN),
    .AD         (AD),
    .Q          (Q),
    .Q_VALID    (Q_VALID),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [9:0] beat_word(input int k);
    logic [3:0] hi;
    logic [5:0] lo;
    hi = 4'(k % 16);
    lo = 6'(63 - k);
    return {hi, lo};
  endfunction

  initial begin
    RST_N = 1'b0; LOAD_START = 0; WR_VALID = 0; WR_DATA = '0; WR_LAST = 0;
    FETCH_EN = 0; AD = '0;
    step(); step();
    chk("rst_q", Q, 10'h000);
    chk("rst_qv", Q_VALID, 0);
    chk("rst_rdy", WR_READY, 0);
    chk("rst_done", LOAD_DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_len", LEN, 0);
    RST_N = 1'b1;

    // empty memory: every fetch is NOP but valid
    for (int i = 0; i < 4; i++) begin
      FETCH_EN = 1; AD = 6'(i);
      step();
      chk("empty_q", Q, 10'h000);
      chk("empty_qv", Q_VALID, 1);
      chk("empty_len", LEN, 0);
    end
    FETCH_EN = 0;

    // three-beat program with WR_LAST
    LOAD_START = 1;
    step();
    LOAD_START = 0;
    chk("ld3_rdy", WR_READY, 1);
    chk("ld3_busy", BUSY, 1);
    WR_VALID = 1; WR_DATA = 10'b0111_111111; WR_LAST = 0;
    step();
    WR_DATA = 10'b1100_000000;
    step();
    WR_DATA = 10'b0000_000000; WR_LAST = 1;
    step();
    WR_VALID = 0; WR_LAST = 0;
    chk("ld3_done", LOAD_DONE, 1);
    chk("ld3_len", LEN, 3);
    chk("ld3_busy_lo", BUSY, 0);
    chk("ld3_rdy_lo", WR_READY, 0);
    FETCH_EN = 1; AD = 0;
    step();
    chk("ld3_done_pulse", LOAD_DONE, 0);
    chk("f0_q", Q, 10'h1FF);
    chk("f0_qv", Q_VALID, 1);
    AD = 1;
    step();
    chk("f1_q", Q, 10'h300);
    // fetch disabled: Q holds, Q_VALID drops
    FETCH_EN = 0; AD = 5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_q", Q, 10'h300);
      chk("hold_qv", Q_VALID, 0);
    end
    FETCH_EN = 1; AD = 5;
    step();
    chk("f5_nop", Q, 10'h000);
    chk("f5_qv", Q_VALID, 1);

    // WR_VALID in RUN must not write
    FETCH_EN = 0; WR_VALID = 1; WR_DATA = 10'h3FF;
    step();
    WR_VALID = 0;
    chk("run_wr_len", LEN, 3);
    FETCH_EN = 1; AD = 0;
    step();
    chk("run_wr_f0", Q, 10'h1FF);

    // full 64-beat load, no WR_LAST, with a gap, a stray LOAD_START and fetches
    FETCH_EN = 0;
    LOAD_START = 1;
    step();
    LOAD_START = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 20) begin
        WR_VALID = 0; WR_DATA = 10'h155;
        step();
        chk("gap_len", LEN, 20);
      end
      WR_VALID = 1; WR_DATA = beat_word(k);
      LOAD_START = (k == 10);
      FETCH_EN = (k == 5); AD = 0;
      step();
      if (k == 5) begin
        chk("ld_fetch_q", Q, 10'h000);
        chk("ld_fetch_qv", Q_VALID, 0);
      end
      if (k == 30) chk("ld_len30", LEN, 31);
      if (k < 63) chk("ld_busy", BUSY, 1);
    end
    WR_VALID = 0; LOAD_START = 0;
    chk("full_done", LOAD_DONE, 1);
    chk("full_len", LEN, 64);
    chk("full_rdy", WR_READY, 0);
    FETCH_EN = 1; AD = 63;
    step();
    chk("full_f63", Q, {22'd0, beat_word(63)});
    AD = 20;
    step();
    chk("full_f20", Q, {22'd0, beat_word(20)});
    AD = 11;
    step();
    chk("full_f11", Q, {22'd0, beat_word(11)});
    AD = 63;
    step();
    FETCH_EN = 0;

    // partial load aborted by asynchronous reset
    LOAD_START = 1;
    step();
    LOAD_START = 0;
    WR_VALID = 1;
    for (int k = 0; k < 10; k++) begin
      WR_DATA = 10'(k + 1);
      step();
    end
    WR_VALID = 0;
    chk("pre_rst_len", LEN, 10);
    chk("pre_rst_q", Q, {22'd0, beat_word(63)});
    #2 RST_N = 1'b0;
    #1;
    chk("arst_len", LEN, 0);
    chk("arst_q", Q, 10'h000);
    chk("arst_busy", BUSY, 0);
    chk("arst_rdy", WR_READY, 0);
    #1 RST_N = 1'b1;
    FETCH_EN = 1; AD = 2;
    step();
    chk("arst_f2", Q, 10'h000);
    chk("arst_f2_qv", Q_VALID, 1);
    chk("arst_run", BUSY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
